datagen_seq: RTL and testbench

Frame sequencer for the data generator feeding the Zynq DMA S2MM channel. Software programs frame length, seed and mode through four 32-bit registers decoded by the S00_AXI AXI4-Lite wrapper. The block then emits fixed-length AXI4-Stream frames with TLAST, honours backpressure and reports progress through a status register. It sits between the AXI4-Lite register slave and the DMA stream input.

---
 rtl/datagen_seq.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_datagen_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datagen_seq.sv
// -----------------------------------------------------------------------------
// datagen_seq : frame sequencer for the DMA S2MM data generator.
//
// Software programs CTRL/LENGTH/SEED through a simple strobe register port.
// A start launches fixed-length AXI4-Stream frames with TLAST. Continuous mode
// repeats frames back to back, and abort ends the stream after the current
// frame. Progress is reported in STATUS and on a level interrupt.
//
// Optional build macro:
//   DATAGEN_LFSR_EN - data from a 32-bit Galois LFSR (taps 0x80200003,
//                     right shift) instead of an incrementing counter.
//
// Ports:
//   ACLK, ARESET      clock, asynchronous active-high reset
//   reg_wr/reg_rd    one-cycle write/read strobes
//   reg_addr         word index: 0 CTRL, 1 LENGTH, 2 SEED, 3 STATUS
//   reg_wdata        write data
//   reg_rdata        registered read data, valid with reg_rvalid
//   reg_rvalid       one-cycle read-data valid
//   M_AXIS_*         AXI4-Stream master (TDATA/TVALID/TLAST out, TREADY in)
//   irq              high while STATUS.done is set
// -----------------------------------------------------------------------------
module datagen_seq #(
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_rvalid,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef DATAGEN_LFSR_EN
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
`endif

    // Next data word after a handshake.
    function automatic logic [31:0] next_data(input logic [31:0] d);
`ifdef DATAGEN_LFSR_EN
        if (d[0]) begin
            next_data = (d >> 1) ^ LFSR_TAPS;
        end else begin
            next_data = d >> 1;
        end
`else
        next_data = d + 32'd1;
`endif
    endfunction

    // First data word of a run, derived from SEED. An all-zero LFSR would
    // lock up, so a zero seed is promoted to 1 in that build.
    function automatic logic [31:0] load_data(input logic [31:0] seed);
`ifdef DATAGEN_LFSR_EN
        if (seed == 32'd0) begin
            load_data = 32'd1;
        end else begin
            load_data = seed;
        end
`else
        load_data = seed;
`endif
    endfunction

    // Registers
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;          // programmed LENGTH
    logic [31:0]        seed_q, seed_d;
    logic               cont_q, cont_d;
    logic [LEN_W-1:0]   act_len_q, act_len_d;  // length of the frame in flight
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               abort_pend_q, abort_pend_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    // Decodes
    logic        wr_ctrl_s, wr_len_s, wr_seed_s, wr_stat_s;
    logic        start_s, abort_s, handshake_s, last_beat_s;
    logic        abort_any_s, cont_ok_s, busy_s;
    logic [15:0] frame_rd_s;
    logic [31:0] status_s, len_rd_s;

    assign wr_ctrl_s   = reg_wr & (reg_addr == 2'd0);
    assign wr_len_s    = reg_wr & (reg_addr == 2'd1);
    assign wr_seed_s   = reg_wr & (reg_addr == 2'd2);
    assign wr_stat_s   = reg_wr & (reg_addr == 2'd3);
    assign start_s     = wr_ctrl_s & reg_wdata[0];
    assign abort_s     = wr_ctrl_s & reg_wdata[2];
    assign handshake_s = tvalid_q & M_AXIS_TREADY;
    assign last_beat_s = (beat_q == (act_len_q - LEN_ONE));
    // An abort written on the final beat's cycle still stops the stream there.
    assign abort_any_s = abort_pend_q | abort_s;
    // A zero LENGTH at a continuous boundary cannot start a frame; stop instead.
    assign cont_ok_s   = cont_q & ~abort_any_s & (len_q != LEN_ZERO);
    assign busy_s      = (state_q != ST_IDLE);
    assign frame_rd_s  = 16'(frame_q);
    assign len_rd_s    = 32'(len_q);
    assign status_s    = {frame_rd_s, 13'd0, err_q, done_q, busy_s};

    // Next-state, register-file and stream-output logic.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        seed_d       = seed_q;
        cont_d       = cont_q;
        act_len_d    = act_len_q;
        beat_d       = beat_q;
        data_d       = data_q;
        frame_d      = frame_q;
        done_d       = done_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        rdata_d      = rdata_q;
        rvalid_d     = reg_rd;

        if (wr_ctrl_s) begin
            cont_d = reg_wdata[1];
        end else begin
            cont_d = cont_q;
        end
        if (wr_len_s) begin
            len_d = reg_wdata[LEN_W-1:0];
        end else begin
            len_d = len_q;
        end
        if (wr_seed_s) begin
            seed_d = reg_wdata;
        end else begin
            seed_d = seed_q;
        end
        // W1C first so that a same-cycle set from the FSM below wins.
        if (wr_stat_s && reg_wdata[1]) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        if (wr_stat_s && reg_wdata[2]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start_s) begin
                    if (len_q != LEN_ZERO) begin
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                act_len_d = len_q;
                data_d    = load_data(seed_q);
                beat_d    = LEN_ZERO;
                frame_d   = CNT_ZERO;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (abort_s) begin
                    abort_pend_d = 1'b1;
                end else begin
                    abort_pend_d = abort_pend_q;
                end
                if (handshake_s) begin
                    data_d = next_data(data_q);
                    beat_d = beat_q + LEN_ONE;
                    if (last_beat_s) begin
                        if (frame_q != CNT_MAX) begin
                            frame_d = frame_q + CNT_ONE;
                        end else begin
                            frame_d = frame_q;
                        end
                        if (cont_ok_s) begin
                            beat_d    = LEN_ZERO;
                            act_len_d = len_q;
                        end else begin
                            state_d      = ST_IDLE;
                            done_d       = 1'b1;
                            abort_pend_d = 1'b0;
                            if (cont_q && !abort_any_s) begin
                                err_d = 1'b1;
                            end else begin
                                err_d = err_d;
                            end
                        end
                    end else begin
                        frame_d = frame_q;
                    end
                end else begin
                    data_d = data_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reg_rd) begin
            case (reg_addr)
                2'd0:    rdata_d = {29'd0, 1'b0, cont_q, 1'b0};
                2'd1:    rdata_d = len_rd_s;
                2'd2:    rdata_d = seed_q;
                2'd3:    rdata_d = status_s;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end

        // Stream flags are registered from the next-state view so they line
        // up with the data register; during a stall beat/length are held.
        tvalid_d = (state_d == ST_RUN);
        if (tvalid_d) begin
            tlast_d = (beat_d == (act_len_d - LEN_ONE));
        end else begin
            tlast_d = 1'b0;
        end
    end

    // State and register update with asynchronous reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            len_q        <= LEN_ZERO;
            seed_q       <= 32'd0;
            cont_q       <= 1'b0;
            act_len_q    <= LEN_ZERO;
            beat_q       <= LEN_ZERO;
            data_q       <= 32'd0;
            frame_q      <= CNT_ZERO;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            seed_q       <= seed_d;
            cont_q       <= cont_d;
            act_len_q    <= act_len_d;
            beat_q       <= beat_d;
            data_q       <= data_d;
            frame_q      <= frame_d;
            done_q       <= done_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign M_AXIS_TDATA  = data_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign reg_rdata     = rdata_q;
    assign reg_rvalid    = rvalid_q;
    assign irq           = done_q;

endmodule

// File: tb/tb_datagen_seq.sv
module tb_datagen_seq;

    logic        ACLK;
    logic        ARESET;
    logic        reg_wr;
    logic        reg_rd;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic        irq;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    datagen_seq #(.LEN_W(16), .CNT_W(16)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .reg_wr        (reg_wr),
        .reg_rd        (reg_rd),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata),
        .reg_rvalid    (reg_rvalid),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .irq           (irq)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Expected data sequence of the selected pattern.
    function automatic logic [31:0] nxt(input logic [31:0] d);
`ifdef DATAGEN_LFSR_EN
        nxt = d[0] ? ((d >> 1) ^ 32'h8020_0003) : (d >> 1);
`else
        nxt = d + 32'd1;
`endif
    endfunction

    function automatic logic [31:0] first(input logic [31:0] seed);
`ifdef DATAGEN_LFSR_EN
        first = (seed == 32'd0) ? 32'd1 : seed;
`else
        first = seed;
`endif
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        reg_wr    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_wr    = 1'b0;
        reg_wdata = 32'd0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a,
                            input logic [31:0] mask, input logic [31:0] exp);
        reg_rd   = 1'b1;
        reg_addr = a;
        tick();
        reg_rd   = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, reg_rvalid}, 32'd1);
        chk(tag, reg_rdata & mask, exp);
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic l);
        chk({tag, "_tvalid"}, {31'd0, M_AXIS_TVALID}, 32'd1);
        chk({tag, "_tdata"},  M_AXIS_TDATA, d);
        chk({tag, "_tlast"},  {31'd0, M_AXIS_TLAST}, {31'd0, l});
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] seq [0:3];
        int          idx [0:6];

        ARESET        = 1'b1;
        reg_wr        = 1'b0;
        reg_rd        = 1'b0;
        reg_addr      = 2'd0;
        reg_wdata     = 32'd0;
        M_AXIS_TREADY = 1'b1;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("rst_tlast",  {31'd0, M_AXIS_TLAST}, 32'd0);
        chk("rst_tdata",  M_AXIS_TDATA, 32'd0);
        chk("rst_irq",    {31'd0, irq}, 32'd0);
        chk("rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
        chk("rst_rdata",  reg_rdata, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        tick();
        read_chk("rst_ctrl",   2'd0, 32'hFFFF_FFFF, 32'd0);
        read_chk("rst_len",    2'd1, 32'hFFFF_FFFF, 32'd0);
        read_chk("rst_seed",   2'd2, 32'hFFFF_FFFF, 32'd0);
        read_chk("rst_status", 2'd3, 32'hFFFF_FFFF, 32'd0);

        // ---- A: LENGTH 4, SEED 0x10, TREADY high ----
        reg_write(2'd1, 32'd4);
        reg_write(2'd2, 32'h10);
        reg_write(2'd0, 32'h1);
        chk("a_load_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        read_chk("a_busy", 2'd3, 32'h0000_0001, 32'h1);
        d = first(32'h10);
        for (int i = 0; i < 4; i++) begin
            seq[i] = d;
            chk_beat("a_beat", d, (i == 3));
            d = nxt(d);
            tick();
        end
        chk("a_end_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("a_irq", {31'd0, irq}, 32'd1);
        read_chk("a_status", 2'd3, 32'hFFFF_FFFF, 32'h0001_0002);
        reg_write(2'd3, 32'h2);
        chk("a_irq_clr", {31'd0, irq}, 32'd0);

        // ---- B: same frame, TREADY 1-0-1-0... ----
        idx[0] = 0; idx[1] = 1; idx[2] = 1; idx[3] = 2;
        idx[4] = 2; idx[5] = 3; idx[6] = 3;
        reg_write(2'd0, 32'h1);
        tick();
        for (int i = 0; i < 7; i++) begin
            M_AXIS_TREADY = ((i % 2) == 0);
            chk_beat("b_beat", seq[idx[i]], (idx[i] == 3));
            tick();
        end
        M_AXIS_TREADY = 1'b1;
        chk("b_end_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("b_irq", {31'd0, irq}, 32'd1);
        reg_write(2'd3, 32'h2);

        // ---- C: cont, LENGTH 3, SEED 0, abort during beat 4 ----
        reg_write(2'd1, 32'd3);
        reg_write(2'd2, 32'd0);
        reg_write(2'd0, 32'h3);
        tick();
        d = first(32'd0);
        for (int i = 0; i < 6; i++) begin
            chk_beat("c_beat", d, (i == 2) || (i == 5));
            d = nxt(d);
            if (i == 4) begin
                reg_write(2'd0, 32'h6);
            end else begin
                tick();
            end
        end
        chk("c_end_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("c_irq", {31'd0, irq}, 32'd1);
        read_chk("c_status", 2'd3, 32'hFFFF_FFFF, 32'h0002_0002);
        read_chk("c_ctrl",   2'd0, 32'hFFFF_FFFF, 32'h2);
        reg_write(2'd0, 32'h0);
        reg_write(2'd3, 32'h2);

        // ---- D: LENGTH 0 start -> err ----
        reg_write(2'd1, 32'd0);
        reg_write(2'd0, 32'h1);
        chk("d_tvalid0", {31'd0, M_AXIS_TVALID}, 32'd0);
        tick();
        chk("d_tvalid1", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("d_irq", {31'd0, irq}, 32'd0);
        read_chk("d_err", 2'd3, 32'h0000_0007, 32'h4);
        reg_write(2'd3, 32'h4);
        read_chk("d_err_clr", 2'd3, 32'h0000_0007, 32'h0);

        // ---- E: reset mid-frame (beat 2 of 8), then a fresh frame ----
        reg_write(2'd1, 32'd8);
        reg_write(2'd2, 32'h100);
        reg_write(2'd0, 32'h1);
        tick();
        d = first(32'h100);
        d = nxt(nxt(d));
        tick();
        tick();
        chk_beat("e_beat2", d, 1'b0);
        ARESET = 1'b1;
        #1;
        chk("e_rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("e_rst_tdata",  M_AXIS_TDATA, 32'd0);
        chk("e_rst_tlast",  {31'd0, M_AXIS_TLAST}, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        tick();
        read_chk("e_len",    2'd1, 32'hFFFF_FFFF, 32'd0);
        read_chk("e_seed",   2'd2, 32'hFFFF_FFFF, 32'd0);
        read_chk("e_status", 2'd3, 32'hFFFF_FFFF, 32'd0);
        reg_write(2'd1, 32'd2);
        reg_write(2'd2, 32'h5);
        reg_write(2'd0, 32'h1);
        tick();
        d = first(32'h5);
        chk_beat("e_new0", d, 1'b0);
        tick();
        chk_beat("e_new1", nxt(d), 1'b1);
        tick();
        chk("e_new_irq", {31'd0, irq}, 32'd1);
        read_chk("e_new_status", 2'd3, 32'hFFFF_FFFF, 32'h0001_0002);
        reg_write(2'd3, 32'h2);

`ifdef DATAGEN_LFSR_EN
        // ---- F: LFSR sequence from seed 1 ----
        reg_write(2'd1, 32'd3);
        reg_write(2'd2, 32'd1);
        reg_write(2'd0, 32'h1);
        tick();
        chk_beat("f_lfsr0", 32'h0000_0001, 1'b0);
        tick();
        chk_beat("f_lfsr1", 32'h8020_0003, 1'b0);
        tick();
        chk_beat("f_lfsr2", 32'hC030_0002, 1'b1);
        tick();
        chk("f_irq", {31'd0, irq}, 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
